// File: rtl/smag_pwm.sv
// Sign-magnitude word to complementary dead-timed PWM; one capture per 2^CW-clock frame.
// Capture takes effect at the next cnt = 0; outputs lag raw compare by 1 (fall) / DT+1 (rise) clocks; no backpressure, inputs are sampled only on 'sample'.
module smag_pwm #(
    parameter int CW    = 8,
    parameter int SHIFT = 8,
    parameter int DT    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   in_mag,
    input  logic          in_sign,
    output logic          sample,
    output logic [CW-1:0] duty,
    output logic          sat,
    output logic          pwm_hi,
    output logic          pwm_lo
);

    localparam logic [CW-1:0]      MID_D = {1'b1, {(CW-1){1'b0}}};
    localparam logic signed [31:0] MID_S = 32'sd1 <<< (CW-1);
    localparam logic signed [31:0] MAX_S = (32'sd1 <<< CW) - 32'sd1;

    logic [CW-1:0]      cnt;
    logic [CW-1:0]      duty_q;
    logic [CW-1:0]      duty_nxt;
    logic               sat_q;
    logic               sat_nxt;
    logic [15:0]        mag_sh;
    logic signed [31:0] mag_s;
    logic signed [31:0] v;
    logic               raw;
    logic [DT:0]        sh;

    assign mag_sh = in_mag >> SHIFT;
    assign mag_s  = $signed({16'd0, mag_sh});

    // Offset mapping around MID with clamping into the counter range.
    always_comb begin
        v        = in_sign ? (MID_S + mag_s) : (MID_S - mag_s);
        duty_nxt = v[CW-1:0];
        sat_nxt  = 1'b0;
        if (v > MAX_S) begin
            duty_nxt = '1;
            sat_nxt  = 1'b1;
        end else if (v < 0) begin
            duty_nxt = '0;
            sat_nxt  = 1'b1;
        end
    end

    assign sample = (cnt == {CW{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            duty_q <= MID_D;
            sat_q  <= 1'b0;
        end else begin
            cnt <= cnt + CW'(1);
            if (sample) begin
                duty_q <= duty_nxt;
                sat_q  <= sat_nxt;
            end
        end
    end

    assign raw = (cnt < duty_q);

    // Both outputs need DT+1 agreeing raw samples, which opens the dead-time gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else begin
            sh[0] <= raw;
            for (int i = 1; i <= DT; i++) begin
                sh[i] <= sh[i-1];
            end
        end
    end

    assign pwm_hi = &sh;
    assign pwm_lo = ~|sh;
    assign duty   = duty_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_smag_pwm.sv
// Scoreboarded bench for smag_pwm: captured words queue expected duty/sat, popped at frame start.
module tb_smag_pwm;

    localparam int CW    = 8;
    localparam int SHIFT = 8;
    localparam int DT    = 2;
    localparam int MID   = 128;
    localparam int FMAX  = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_mag;
    logic        in_sign;
    logic        sample;
    logic [7:0]  duty;
    logic        sat;
    logic        pwm_hi;
    logic        pwm_lo;

    always #5 clk = ~clk;

    smag_pwm #(.CW(CW), .SHIFT(SHIFT), .DT(DT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_mag  (in_mag),
        .in_sign (in_sign),
        .sample  (sample),
        .duty    (duty),
        .sat     (sat),
        .pwm_hi  (pwm_hi),
        .pwm_lo  (pwm_lo)
    );

    typedef struct packed {logic [15:0] mag; logic sign;} stim_t;
    typedef struct packed {logic [7:0] d; logic sat;} exp_t;

    stim_t stim_q[$];
    exp_t  sb_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          bcnt;
    int          exp_d;
    logic        exp_sat;
    logic [DT:0] raw_hist;
    int          hi_w, hi_first, lo_rise, lo_any;
    logic        prev_lo;
    int          last_side, gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cnt %0d, t=%0t)", tag, got, exp, bcnt, $time);
        end
    endtask

    function automatic exp_t map_duty(input logic [15:0] mag, input logic sign);
        exp_t e;
        int   m;
        int   v;
        m = int'(mag) >> SHIFT;
        v = sign ? MID + m : MID - m;
        if (v > FMAX)   begin e.d = 8'd255; e.sat = 1'b1; end
        else if (v < 0) begin e.d = 8'd0;   e.sat = 1'b1; end
        else            begin e.d = 8'(v);  e.sat = 1'b0; end
        return e;
    endfunction

    function automatic stim_t stim_for(input int d);
        stim_t s;
        if (d >= MID) begin s.mag = 16'((d - MID) << 8); s.sign = 1'b1; end
        else          begin s.mag = 16'((MID - d) << 8); s.sign = 1'b0; end
        return s;
    endfunction

    task automatic model_reset();
        bcnt      = 0;
        exp_d     = MID;
        exp_sat   = 1'b0;
        raw_hist  = '0;
        sb_q.delete();
        prev_lo   = 1'b1;
        last_side = 2;
        gap       = 0;
    endtask

    // Observe one DUT cycle, drive inputs for it, advance the model, wait for the next cycle.
    task automatic cycle_step();
        stim_t s;
        exp_t  e;
        if (bcnt == 0) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                exp_d   = int'(e.d);
                exp_sat = e.sat;
            end
            hi_w = 0; hi_first = -1; lo_rise = -1; lo_any = 0;
        end
        check("duty", 32'(duty), 32'(exp_d));
        check("sat", 32'(sat), 32'(exp_sat));
        check("sample", 32'(sample), 32'(bcnt == FMAX));
        check("pwm_hi", 32'(pwm_hi), 32'(&raw_hist));
        check("pwm_lo", 32'(pwm_lo), 32'(~|raw_hist));
        check("excl", 32'(pwm_hi & pwm_lo), 32'd0);

        if (pwm_hi) begin
            if (last_side == 2) check("gap_lo_hi", 32'(gap >= DT), 32'd1);
            last_side = 1; gap = 0;
        end else if (pwm_lo) begin
            if (last_side == 1) check("gap_hi_lo", 32'(gap >= DT), 32'd1);
            last_side = 2; gap = 0;
        end else begin
            gap++;
        end

        if (pwm_hi) begin
            hi_w++;
            if (hi_first < 0) hi_first = bcnt;
        end
        if (pwm_lo && bcnt != 0) lo_any++;
        if (pwm_lo && !prev_lo && bcnt != 0 && lo_rise < 0) lo_rise = bcnt;
        prev_lo = pwm_lo;

        if (bcnt == FMAX) begin
            if (exp_d > DT) begin
                check("hi_width", 32'(hi_w), 32'(exp_d - DT));
                check("hi_first", 32'(hi_first), 32'(DT + 1));
            end else begin
                check("hi_width", 32'(hi_w), 32'd0);
            end
            if (exp_d >= 1 && exp_d + DT + 1 <= FMAX) check("lo_rise", 32'(lo_rise), 32'(exp_d + DT + 1));
            else if (exp_d >= 1)                      check("lo_rise", 32'(lo_rise), 32'hFFFF_FFFF);
            if (exp_d == FMAX) check("lo_never", 32'(lo_any), 32'd0);
            if (stim_q.size() > 0) s = stim_q.pop_front();
            else begin s.mag = 16'd0; s.sign = 1'b1; end
            in_mag  = s.mag;
            in_sign = s.sign;
            sb_q.push_back(map_duty(s.mag, s.sign));
        end else begin
            in_mag  = 16'($urandom);
            in_sign = 1'($urandom);
        end

        raw_hist = {raw_hist[DT-1:0], (bcnt < exp_d)};
        bcnt     = (bcnt + 1) % (FMAX + 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        in_mag  = 16'd0;
        in_sign = 1'b1;
        repeat (2) @(negedge clk);
        bcnt = 0;
        check("rst_hi", 32'(pwm_hi), 32'd0);
        check("rst_lo", 32'(pwm_lo), 32'd1);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_duty", 32'(duty), 32'd128);

        stim_q.push_back('{mag: 16'h4000, sign: 1'b1});
        stim_q.push_back('{mag: 16'h4000, sign: 1'b0});
        stim_q.push_back('{mag: 16'h0000, sign: 1'b0});
        stim_q.push_back('{mag: 16'hFFFF, sign: 1'b1});
        stim_q.push_back('{mag: 16'hFFFF, sign: 1'b0});
        stim_q.push_back('{mag: 16'h0000, sign: 1'b1});
        for (int d = 0; d <= FMAX; d += 5) stim_q.push_back(stim_for(d));
        stim_q.push_back(stim_for(1));
        stim_q.push_back(stim_for(2));
        stim_q.push_back(stim_for(3));
        stim_q.push_back(stim_for(252));
        stim_q.push_back(stim_for(253));
        stim_q.push_back(stim_for(254));
        stim_q.push_back(stim_for(255));
        stim_q.push_back('{mag: 16'h4000, sign: 1'b1});
        n = stim_q.size();

        rst_n = 1'b1;
        #1;
        model_reset();
        repeat (n * 256) cycle_step();

        // Now at cnt 0 of the duty-192 frame; reset asynchronously at cnt 100.
        repeat (100) cycle_step();
        #1;
        check("pre_rst_hi", 32'(pwm_hi), 32'd1);
        check("pre_rst_duty", 32'(duty), 32'd192);
        rst_n = 1'b0;
        #1;
        check("arst_hi", 32'(pwm_hi), 32'd0);
        check("arst_lo", 32'(pwm_lo), 32'd1);
        check("arst_duty", 32'(duty), 32'd128);
        check("arst_sample", 32'(sample), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        model_reset();
        repeat (512) cycle_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
